key_expr_entry: RTL

Parametrised keypad expression-entry controller for the calculator datapath: turns a stream of 4-bit key codes into "operand A, operator, operand B" and presents them to the ALU stage.
- Replaces the fixed 3-digit/16-bit tri-state-bus entry block.
- Registered outputs; valid/ready handshake instead of a write-enable bus.
- Configurable digit limit, operand width and key codes.
- Sits between the keypad scanner/debouncer and the ALU/display sequencer.

---
 rtl/key_pkg.sv | 19 +
 rtl/key_accum.sv | 65 ++++++
 rtl/key_expr_entry.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/key_pkg.sv
// Shared types and constants for the keypad expression-entry controller.
package key_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_OPA  = 3'd1,
    ST_OPR  = 3'd2,
    ST_OPB  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic [3:0] KEY_EQ_DFLT = 4'hF;
  localparam logic [3:0] KEY_BS_DFLT = 4'hE;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/key_accum.sv
// Per-operand decimal accumulator: digit limit, drop flag and, with KEY_BACKSPACE_EN, divide-by-10 undo.
module key_accum #(
  parameter int unsigned DIGITS = 3,
  parameter int unsigned OPW    = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         load,
  input  logic                         acc,
  input  logic                         bs,
  input  logic [3:0]                   digit,
  output logic [OPW-1:0]               val,
  output logic [$clog2(DIGITS+1)-1:0]  cnt,
  output logic [$clog2(DIGITS+1)-1:0]  cnt_nxt_c,
  output logic                         drop_c
);

  localparam int unsigned CW = $clog2(DIGITS + 1);

  logic [OPW-1:0] val_nxt;

`ifndef KEY_BACKSPACE_EN
  logic unused_bs;
  assign unused_bs = bs;
`endif

  // Priority: clear, first-digit load, accumulate, backspace.
  always_comb begin
    val_nxt   = val;
    cnt_nxt_c = cnt;
    drop_c    = 1'b0;
    if (clr) begin
      val_nxt   = '0;
      cnt_nxt_c = '0;
    end else if (load) begin
      val_nxt   = OPW'(digit);
      cnt_nxt_c = CW'(1);
    end else if (acc) begin
      if (cnt < CW'(DIGITS)) begin
        val_nxt   = val * OPW'(10) + OPW'(digit);
        cnt_nxt_c = cnt + CW'(1);
      end else begin
        drop_c = 1'b1;
      end
    end
`ifdef KEY_BACKSPACE_EN
    else if (bs && (cnt != '0)) begin
      val_nxt   = val / OPW'(10);
      cnt_nxt_c = cnt - CW'(1);
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val <= '0;
      cnt <= '0;
    end else begin
      val <= val_nxt;
      cnt <= cnt_nxt_c;
    end
  end

endmodule

// File: rtl/key_expr_entry.sv
// Keypad expression-entry controller: key codes -> operand A, operator, operand B with valid/ready.
// Optional backspace support via `define KEY_BACKSPACE_EN.
module key_expr_entry
  import key_pkg::*;
#(
  parameter int unsigned DIGITS = 3,
  parameter int unsigned OPW    = 16,
  parameter logic [3:0]  KEY_EQ = KEY_EQ_DFLT,
  parameter logic [3:0]  KEY_BS = KEY_BS_DFLT
) (
  input  logic                         IN_clk,
  input  logic                         IN_reset,
  input  logic                         IN_key,
  input  logic [3:0]                   IN_value,
  input  logic                         IN_clr,
  input  logic                         IN_ready,
  output logic                         OUT_valid,
  output logic [OPW-1:0]               OUT_src,
  output logic [OPW-1:0]               OUT_dst,
  output logic [3:0]                   OUT_alu_op,
  output logic [2:0]                   OUT_state,
  output logic [$clog2(DIGITS+1)-1:0]  OUT_cnt,
  output logic                         OUT_ovf
);

  localparam int unsigned    CW      = $clog2(DIGITS + 1);
  localparam longint unsigned MAX_DEC = (64'd10 ** DIGITS) - 64'd1;
  localparam longint unsigned MAX_OPW = (64'd1 << OPW) - 64'd1;

  generate
    if (MAX_DEC > MAX_OPW) begin : g_param_chk
      $error("key_expr_entry: OPW too narrow to hold DIGITS decimal digits");
    end
  endgenerate

`ifdef KEY_BACKSPACE_EN
  localparam logic BS_EN = 1'b1;
`else
  localparam logic BS_EN = 1'b0;
`endif

  state_t          state, state_nxt;
  logic [3:0]      op_nxt;
  logic            ovf_clr, ovf_nxt, valid_nxt;
  logic [CW-1:0]   cnt_nxt;
  logic            is_dig_c, is_eq_c, is_bs_c, is_op_c;
  logic            a_clr, a_load, a_acc, a_bs, a_drop_c;
  logic            b_clr, b_load, b_acc, b_bs, b_drop_c;
  logic [CW-1:0]   a_cnt, a_cnt_nxt_c, b_cnt, b_cnt_nxt_c;

  assign is_dig_c  = is_digit(IN_value);
  assign is_eq_c   = !is_dig_c && (IN_value == KEY_EQ);
  assign is_bs_c   = BS_EN && !is_dig_c && !is_eq_c && (IN_value == KEY_BS);
  assign is_op_c   = !is_dig_c && !is_eq_c && !is_bs_c;
  assign OUT_state = state;

  key_accum #(.DIGITS(DIGITS), .OPW(OPW)) u_acc_a (
    .clk(IN_clk), .rst_n(IN_reset), .clr(a_clr), .load(a_load), .acc(a_acc), .bs(a_bs),
    .digit(IN_value), .val(OUT_src), .cnt(a_cnt), .cnt_nxt_c(a_cnt_nxt_c), .drop_c(a_drop_c)
  );

  key_accum #(.DIGITS(DIGITS), .OPW(OPW)) u_acc_b (
    .clk(IN_clk), .rst_n(IN_reset), .clr(b_clr), .load(b_load), .acc(b_acc), .bs(b_bs),
    .digit(IN_value), .val(OUT_dst), .cnt(b_cnt), .cnt_nxt_c(b_cnt_nxt_c), .drop_c(b_drop_c)
  );

  // Next-state and operand control; clear wins over keys and handshake.
  always_comb begin
    state_nxt = state;
    op_nxt    = OUT_alu_op;
    ovf_clr   = 1'b0;
    a_clr = 1'b0; a_load = 1'b0; a_acc = 1'b0; a_bs = 1'b0;
    b_clr = 1'b0; b_load = 1'b0; b_acc = 1'b0; b_bs = 1'b0;
    if (IN_clr) begin
      state_nxt = ST_IDLE;
      op_nxt    = '0;
      ovf_clr   = 1'b1;
      a_clr     = 1'b1;
      b_clr     = 1'b1;
    end else begin
      case (state)
        ST_IDLE: if (IN_key) begin
          if (is_dig_c) begin
            a_load    = 1'b1;
            state_nxt = ST_OPA;
          end else if (is_eq_c) begin
            op_nxt  = '0;
            ovf_clr = 1'b1;
            a_clr   = 1'b1;
            b_clr   = 1'b1;
          end else if (is_op_c) begin
            op_nxt    = IN_value;
            ovf_clr   = 1'b1;
            a_clr     = 1'b1;
            b_clr     = 1'b1;
            state_nxt = ST_OPR;
          end
        end
        ST_OPA: if (IN_key) begin
          if (is_dig_c) begin
            a_acc = 1'b1;
          end else if (is_bs_c) begin
            a_bs = 1'b1;
          end else if (is_op_c) begin
            op_nxt    = IN_value;
            ovf_clr   = 1'b1;
            b_clr     = 1'b1;
            state_nxt = ST_OPR;
          end
        end
        ST_OPR: if (IN_key) begin
          if (is_dig_c) begin
            b_load    = 1'b1;
            state_nxt = ST_OPB;
          end else if (is_bs_c) begin
            state_nxt = ST_OPA;
          end else if (is_op_c) begin
            op_nxt = IN_value;
          end
        end
        ST_OPB: if (IN_key) begin
          if (is_dig_c) begin
            b_acc = 1'b1;
          end else if (is_eq_c) begin
            state_nxt = ST_DONE;
          end else if (is_bs_c) begin
            if (b_cnt == CW'(1)) begin
              b_clr     = 1'b1;
              state_nxt = ST_OPR;
            end else begin
              b_bs = 1'b1;
            end
          end
        end
        ST_DONE: if (OUT_valid && IN_ready) begin
          state_nxt = ST_IDLE;
          op_nxt    = '0;
          ovf_clr   = 1'b1;
          a_clr     = 1'b1;
          b_clr     = 1'b1;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Sticky overflow, visible digit count and valid derived from the next state.
  always_comb begin
    ovf_nxt   = ovf_clr ? 1'b0 : (OUT_ovf | a_drop_c | b_drop_c);
    valid_nxt = (state_nxt == ST_DONE);
    case (state_nxt)
      ST_OPA:          cnt_nxt = a_cnt_nxt_c;
      ST_OPB, ST_DONE: cnt_nxt = b_cnt_nxt_c;
      default:         cnt_nxt = '0;
    endcase
  end

  always_ff @(posedge IN_clk or negedge IN_reset) begin
    if (!IN_reset) begin
      state      <= ST_IDLE;
      OUT_alu_op <= '0;
      OUT_ovf    <= 1'b0;
      OUT_valid  <= 1'b0;
      OUT_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      OUT_alu_op <= op_nxt;
      OUT_ovf    <= ovf_nxt;
      OUT_valid  <= valid_nxt;
      OUT_cnt    <= cnt_nxt;
    end
  end

  logic unused_a_cnt;
  assign unused_a_cnt = ^a_cnt;

endmodule
